// File: rtl/loader_pkg.sv
// Shared definitions for the serial program loader: FSM state encoding,
// header/word geometry and the running checksum helper.
package loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_HDR_LO  = 3'd1,
        ST_HDR_HI  = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_WRITE   = 3'd4,
        ST_CHECK   = 3'd5,
        ST_DONE    = 3'd6,
        ST_ERROR   = 3'd7
    } loader_state_t;

    localparam int HEADER_BYTES   = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int COUNT_W        = HEADER_BYTES * 8;

    // Running checksum: XOR of every payload byte seen so far.
    function automatic logic [7:0] checksum_update(input logic [7:0] acc,
                                                   input logic [7:0] data);
        return acc ^ data;
    endfunction

endpackage

// File: rtl/word_packer.sv
// Assembles little-endian bytes into 32-bit words. Byte k of a word lands in
// bits [8k+7:8k]; word_last flags the byte that completes a word.
module word_packer
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        byte_en,
    input  logic [7:0]  byte_in,
    output logic [31:0] word,
    output logic [1:0]  byte_index,
    output logic        word_last
);

    logic [31:0] word_r;
    logic [1:0]  byte_index_r;

    assign word       = word_r;
    assign byte_index = byte_index_r;
    assign word_last  = byte_en && (byte_index_r == 2'(BYTES_PER_WORD - 1));

    // Byte lane write and lane counter; the counter wraps 3 -> 0 naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            word_r       <= 32'd0;
            byte_index_r <= 2'd0;
        end else if (clear) begin
            byte_index_r <= 2'd0;
        end else if (byte_en) begin
            word_r[{byte_index_r, 3'b000} +: 8] <= byte_in;
            byte_index_r                        <= byte_index_r + 2'd1;
        end else begin
            byte_index_r <= byte_index_r;
        end
    end

endmodule

// File: rtl/program_loader.sv
// Serial program loader: receives a 16-bit little-endian word count followed
// by the payload bytes, writes each assembled word to program memory and
// releases the core from reset on success.
// Optional feature: define LOADER_CHECKSUM_EN to require a trailing XOR
// checksum byte after the payload.
module program_loader
    import loader_pkg::*;
#(
    parameter int PROGRAM_MEMORY_DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Start_i,
    input  logic [7:0]  Byte_i,
    input  logic        Byte_Valid_i,
    output logic        Byte_Ready_o,
    output logic        Mem_Write_o,
    output logic [31:0] Mem_Address_o,
    output logic [31:0] Mem_Write_Data_o,
    output logic        Core_Reset_o,
    output logic        Done_o,
    output logic        Error_o
);

    localparam logic [COUNT_W:0] DEPTH_C = (COUNT_W + 1)'(PROGRAM_MEMORY_DEPTH);

`ifdef LOADER_CHECKSUM_EN
    localparam loader_state_t ST_FINISH = ST_CHECK;
`else
    localparam loader_state_t ST_FINISH = ST_DONE;
`endif

    loader_state_t        state_r;
    loader_state_t        state_s;
    logic [COUNT_W-1:0]   count_r;
    logic [COUNT_W-1:0]   word_index_r;
    logic [COUNT_W-1:0]   hdr_count_s;
    logic                 accept_s;
    logic                 last_word_s;
    logic                 word_last_s;
    logic [1:0]           byte_index_s;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]           xor_r;
`endif

    // Outputs are decoded from the current state only.
    assign Byte_Ready_o  = (state_r == ST_HDR_LO) || (state_r == ST_HDR_HI) ||
                           (state_r == ST_PAYLOAD)
`ifdef LOADER_CHECKSUM_EN
                           || (state_r == ST_CHECK)
`endif
                           ;
    assign Mem_Write_o   = (state_r == ST_WRITE);
    assign Done_o        = (state_r == ST_DONE);
    assign Error_o       = (state_r == ST_ERROR);
    assign Core_Reset_o  = (state_r != ST_DONE);
    assign Mem_Address_o = {14'd0, word_index_r, 2'b00};

    assign accept_s    = Byte_Valid_i && Byte_Ready_o;
    assign hdr_count_s = {Byte_i, count_r[7:0]};
    assign last_word_s = ((word_index_r + 16'd1) == count_r);

    word_packer u_word_packer (
        .clk        (clk),
        .reset      (reset),
        .clear      (accept_s && (state_r == ST_HDR_HI)),
        .byte_en    (accept_s && (state_r == ST_PAYLOAD)),
        .byte_in    (Byte_i),
        .word       (Mem_Write_Data_o),
        .byte_index (byte_index_s),
        .word_last  (word_last_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; Start_i only matters in IDLE, DONE and ERROR.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (Start_i) state_s = ST_HDR_LO;
                else         state_s = state_r;
            end
            ST_HDR_LO: begin
                if (accept_s) state_s = ST_HDR_HI;
                else          state_s = state_r;
            end
            ST_HDR_HI: begin
                if (!accept_s)                               state_s = state_r;
                else if ({1'b0, hdr_count_s} > DEPTH_C)      state_s = ST_ERROR;
                else if (hdr_count_s == 16'd0)               state_s = ST_FINISH;
                else                                         state_s = ST_PAYLOAD;
            end
            ST_PAYLOAD: begin
                if (word_last_s) state_s = ST_WRITE;
                else             state_s = state_r;
            end
            ST_WRITE: begin
                if (last_word_s) state_s = ST_FINISH;
                else             state_s = ST_PAYLOAD;
            end
`ifdef LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (!accept_s)            state_s = state_r;
                else if (Byte_i == xor_r) state_s = ST_DONE;
                else                      state_s = ST_ERROR;
            end
`endif
            default: state_s = ST_IDLE;
        endcase
    end

    // Header count, word index and checksum bookkeeping.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r      <= 16'd0;
            word_index_r <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
            xor_r        <= 8'd0;
`endif
        end else begin
            case (state_r)
                ST_HDR_LO: begin
                    if (accept_s) count_r <= {8'd0, Byte_i};
                end
                ST_HDR_HI: begin
                    if (accept_s) begin
                        count_r      <= hdr_count_s;
                        word_index_r <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                        xor_r        <= 8'd0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                ST_PAYLOAD: begin
                    if (accept_s) xor_r <= checksum_update(xor_r, Byte_i);
                end
`endif
                ST_WRITE: begin
                    word_index_r <= word_index_r + 16'd1;
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a queue of expected memory writes
// and the expected load outcome are built from the word list, and every
// cycle the DUT outputs are compared against them.
module tb_program_loader;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset;
    logic        Start_i;
    logic [7:0]  Byte_i;
    logic        Byte_Valid_i;
    logic        Byte_Ready_o;
    logic        Mem_Write_o;
    logic [31:0] Mem_Address_o;
    logic [31:0] Mem_Write_Data_o;
    logic        Core_Reset_o;
    logic        Done_o;
    logic        Error_o;

    int checks = 0;
    int errors = 0;

    logic [63:0] exp_q[$];      // {address, data} of writes still expected
    logic [7:0]  bytes_q[$];    // payload bytes for the next load
    logic [31:0] exp_words[$];  // words those bytes must produce

    program_loader #(.PROGRAM_MEMORY_DEPTH(DEPTH)) dut (
        .clk              (clk),
        .reset            (reset),
        .Start_i          (Start_i),
        .Byte_i           (Byte_i),
        .Byte_Valid_i     (Byte_Valid_i),
        .Byte_Ready_o     (Byte_Ready_o),
        .Mem_Write_o      (Mem_Write_o),
        .Mem_Address_o    (Mem_Address_o),
        .Mem_Write_Data_o (Mem_Write_Data_o),
        .Core_Reset_o     (Core_Reset_o),
        .Done_o           (Done_o),
        .Error_o          (Error_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of global invariants and of every memory write.
    always @(negedge clk) begin
        logic [63:0] e;
        if (reset === 1'b0) begin
            check("core_reset_iff_not_done", 32'(Core_Reset_o), 32'(!Done_o));
            check("done_error_exclusive", 32'(Done_o & Error_o), 32'd0);
            check("write_while_ready", 32'(Mem_Write_o & Byte_Ready_o), 32'd0);
            if (Mem_Write_o) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected no write",
                             Mem_Address_o, Mem_Write_Data_o);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", Mem_Address_o, e[63:32]);
                    check("write_data", Mem_Write_Data_o, e[31:0]);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_core_reset"}, 32'(Core_Reset_o), 32'd1);
        check({tag, "_ready"}, 32'(Byte_Ready_o), 32'd0);
        check({tag, "_write"}, 32'(Mem_Write_o), 32'd0);
        check({tag, "_addr"}, Mem_Address_o, 32'd0);
        check({tag, "_data"}, Mem_Write_Data_o, 32'd0);
        check({tag, "_done"}, 32'(Done_o), 32'd0);
        check({tag, "_error"}, 32'(Error_o), 32'd0);
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return int'($urandom_range(0, 3));
        return 10;
    endfunction

    // Starts and ends on a falling edge; the transfer happens on the rising
    // edge in between once Byte_Ready_o is seen high.
    task automatic send_byte(input logic [7:0] b, input int gap, input bit glitch);
        int n;
        for (int i = 0; i < gap; i++) begin
            Byte_Valid_i = 1'b0;
            Byte_i       = 8'($urandom);
            Start_i      = glitch && (i == gap / 2);
            @(negedge clk);
        end
        Start_i      = 1'b0;
        Byte_i       = b;
        Byte_Valid_i = 1'b1;
        n = 0;
        while (!Byte_Ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!Byte_Ready_o) begin
            errors++;
            $display("FAIL byte_ready_timeout: got ready %b expected 1 within 50 cycles", Byte_Ready_o);
        end else begin
            @(negedge clk);
        end
        Byte_Valid_i = 1'b0;
    endtask

    task automatic do_start();
        Start_i = 1'b1;
        @(negedge clk);
        Start_i = 1'b0;
        check("start_done_cleared", 32'(Done_o), 32'd0);
        check("start_error_cleared", 32'(Error_o), 32'd0);
        check("start_core_reset", 32'(Core_Reset_o), 32'd1);
    endtask

    // Fill bytes_q/exp_words with n random words, little-endian bytes.
    task automatic make_random(input int n);
        logic [31:0] w;
        bytes_q.delete();
        exp_words.delete();
        for (int i = 0; i < n; i++) begin
            w = $urandom;
            exp_words.push_back(w);
            for (int k = 0; k < 4; k++) bytes_q.push_back(8'(w >> (8 * k)));
        end
    endtask

    // One full load. cks < 0 sends the correct checksum (when enabled).
    task automatic run_load(input string tag, input int n_hdr, input int mode, input int cks);
        logic [7:0] x;
        bit         oversize;
        bit         exp_done;
        bit         glitch;
        int         n;
        x        = 8'd0;
        glitch   = (mode == 2);
        oversize = (n_hdr > DEPTH);
        if (!oversize) begin
            for (int i = 0; i < n_hdr; i++) exp_q.push_back({32'(i * 4), exp_words[i]});
        end
        do_start();
        send_byte(8'(n_hdr), pick_gap(mode), glitch);
        send_byte(8'(n_hdr >> 8), pick_gap(mode), glitch);
        if (!oversize) begin
            for (int i = 0; i < bytes_q.size(); i++) begin
                x = x ^ bytes_q[i];
                send_byte(bytes_q[i], pick_gap(mode), glitch);
            end
        end
        exp_done = !oversize;
`ifdef LOADER_CHECKSUM_EN
        if (!oversize) begin
            logic [7:0] c;
            c = (cks < 0) ? x : 8'(cks);
            exp_done = (c == x);
            send_byte(c, pick_gap(mode), glitch);
        end
`else
        if (cks > 255) $display("note: checksum argument ignored");
`endif
        n = 0;
        while (!(Done_o || Error_o) && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_done"}, 32'(Done_o), 32'(exp_done));
        check({tag, "_error"}, 32'(Error_o), 32'(!exp_done));
        check({tag, "_core_reset"}, 32'(Core_Reset_o), 32'(!exp_done));
        check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic load_req033();
        logic [7:0] b[8] = '{8'h13, 8'h05, 8'h50, 8'h00, 8'h33, 8'h86, 8'hA5, 8'h00};
        bytes_q.delete();
        exp_words.delete();
        for (int i = 0; i < 8; i++) bytes_q.push_back(b[i]);
        exp_words.push_back(32'h00500513);
        exp_words.push_back(32'h00A58633);
    endtask

    initial begin
        reset        = 1'b1;
        Start_i      = 1'b0;
        Byte_i       = 8'd0;
        Byte_Valid_i = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        reset = 1'b0;
        Byte_Valid_i = 1'b1;
        Byte_i       = 8'hAA;
        repeat (3) @(negedge clk);
        check("idle_ready", 32'(Byte_Ready_o), 32'd0);
        check("idle_core_reset", 32'(Core_Reset_o), 32'd1);
        Byte_Valid_i = 1'b0;

        // Two-word reference program, unstalled.
        load_req033();
        run_load("req033", 2, 0, -1);

        // Oversize header 0x0081 -> error, no writes.
        bytes_q.delete();
        exp_words.delete();
        run_load("oversize", 129, 0, -1);

        // Same program with long stalls and stray Start pulses.
        load_req033();
        run_load("stalled", 2, 2, -1);

        // Empty program.
        make_random(0);
        run_load("empty", 0, 1, -1);

        // Exactly full memory.
        make_random(DEPTH);
        run_load("full_depth", DEPTH, 1, -1);

`ifdef LOADER_CHECKSUM_EN
        bytes_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        exp_words = '{32'h04030201};
        run_load("bad_checksum", 1, 0, 8'h05);
        check("bad_checksum_lit_error", 32'(Error_o), 32'd1);
        exp_words = '{32'h04030201};
        run_load("good_checksum", 1, 0, 8'h04);
        check("good_checksum_lit_done", 32'(Done_o), 32'd1);
`endif

        // Reset after two of four payload bytes.
        do_start();
        send_byte(8'h01, 0, 1'b0);
        send_byte(8'h00, 0, 1'b0);
        send_byte(8'hDE, 0, 1'b0);
        send_byte(8'hAD, 0, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_reset_outputs("midload");
        reset        = 1'b0;
        Byte_Valid_i = 1'b1;
        Byte_i       = 8'hBE;
        repeat (5) @(negedge clk);
        check("post_reset_idle_ready", 32'(Byte_Ready_o), 32'd0);
        check("post_reset_no_data", Mem_Write_Data_o, 32'd0);
        Byte_Valid_i = 1'b0;
        make_random(1);
        run_load("after_reset", 1, 0, -1);

        // Randomized loads, restarting straight from DONE/ERROR.
        for (int t = 0; t < 15; t++) begin
            int n;
            int cks;
            n   = int'($urandom_range(1, 6));
            cks = -1;
            if ($urandom_range(0, 9) == 0) n = int'($urandom_range(DEPTH + 1, 65535));
            if ($urandom_range(0, 4) == 0) cks = int'($urandom_range(0, 255));
            make_random((n > DEPTH) ? 0 : n);
            run_load("random", n, 1, cks);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
